// File: rtl/byte_serializer_tx.sv
// MSB-first parallel-to-serial transmitter with valid/ready word accept and frame strobe.
// Optional even-parity bit after bit 0 is compiled in with `define BYTE_SERIALIZER_TX_PARITY_EN.
module byte_serializer_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] d,
  input  logic              d_valid,
  output logic              d_ready,
  output logic              sdo,
  output logic              sframe,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [3:0]        GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
    PARITY   = 2'd2,
`endif
    GAP_WAIT = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  shreg, shreg_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [3:0]         gap_cnt, gap_cnt_n;
  logic               sdo_n, sframe_n, busy_n;
  logic               frame_end;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
  logic               parity_q, parity_n;
`endif

  assign d_ready = (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    sdo_n     = 1'b0;
    sframe_n  = 1'b0;
    frame_end = 1'b0;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
    parity_n  = parity_q;
`endif

    case (state)
      IDLE: begin
        if (d_valid) begin
          state_n   = SHIFT;
          shreg_n   = d;
          bit_cnt_n = '0;
          sdo_n     = d[DATA_W-1];
          sframe_n  = 1'b1;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
          parity_n  = ^d;
`endif
        end
      end
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
          state_n  = PARITY;
          sdo_n    = parity_q;
          sframe_n = 1'b1;
`else
          frame_end = 1'b1;
`endif
        end else begin
          // sdo currently shows shreg's MSB; the next bit sits just below it.
          bit_cnt_n = bit_cnt + 1'b1;
          shreg_n   = shreg << 1;
          sdo_n     = shreg[DATA_W-2];
          sframe_n  = 1'b1;
        end
      end
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
      PARITY: frame_end = 1'b1;
`endif
      GAP_WAIT: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else                     gap_cnt_n = gap_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (frame_end) begin
      if (GAP == 0) begin
        state_n = IDLE;
      end else begin
        state_n   = GAP_WAIT;
        gap_cnt_n = '0;
      end
    end

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sdo     <= 1'b0;
      sframe  <= 1'b0;
      busy    <= 1'b0;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      sdo     <= sdo_n;
      sframe  <= sframe_n;
      busy    <= busy_n;
`ifdef BYTE_SERIALIZER_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

endmodule

// File: tb/tb_byte_serializer_tx.sv
// Directed bench for byte_serializer_tx: three instances with GAP = 1, 2 and 0, DATA_W = 8.
module tb_byte_serializer_tx;

`ifdef BYTE_SERIALIZER_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] d [3];
  logic [2:0] d_valid, d_ready, sdo, sframe, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  byte_serializer_tx #(.DATA_W(8), .GAP(1)) u_gap1 (
    .clk(clk), .resetn(resetn), .d(d[0]), .d_valid(d_valid[0]),
    .d_ready(d_ready[0]), .sdo(sdo[0]), .sframe(sframe[0]), .busy(busy[0]));
  byte_serializer_tx #(.DATA_W(8), .GAP(2)) u_gap2 (
    .clk(clk), .resetn(resetn), .d(d[1]), .d_valid(d_valid[1]),
    .d_ready(d_ready[1]), .sdo(sdo[1]), .sframe(sframe[1]), .busy(busy[1]));
  byte_serializer_tx #(.DATA_W(8), .GAP(0)) u_gap0 (
    .clk(clk), .resetn(resetn), .d(d[2]), .d_valid(d_valid[2]),
    .d_ready(d_ready[2]), .sdo(sdo[2]), .sframe(sframe[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int gap_of(input int u);
    case (u)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  // Called one step after the accept edge; returns in the first IDLE cycle after the frame.
  task automatic run_frame(input int u, input logic [7:0] w, input int mod_at, input logic [7:0] mod_val);
    for (int i = 0; i < 8; i++) begin
      if (i == mod_at) d[u] = mod_val;
      check($sformatf("u%0d bit%0d sdo", u, i), 32'(sdo[u]), 32'(w[7-i]));
      check($sformatf("u%0d bit%0d sframe", u, i), 32'(sframe[u]), 32'd1);
      check($sformatf("u%0d bit%0d busy", u, i), 32'(busy[u]), 32'd1);
      check($sformatf("u%0d bit%0d d_ready", u, i), 32'(d_ready[u]), 32'd0);
      tick();
    end
    if (P == 1) begin
      check($sformatf("u%0d parity sdo", u), 32'(sdo[u]), 32'(^w));
      check($sformatf("u%0d parity sframe", u), 32'(sframe[u]), 32'd1);
      tick();
    end
    for (int g = 0; g < gap_of(u); g++) begin
      check($sformatf("u%0d gap%0d sframe", u, g), 32'(sframe[u]), 32'd0);
      check($sformatf("u%0d gap%0d sdo", u, g), 32'(sdo[u]), 32'd0);
      check($sformatf("u%0d gap%0d busy", u, g), 32'(busy[u]), 32'd1);
      check($sformatf("u%0d gap%0d d_ready", u, g), 32'(d_ready[u]), 32'd0);
      tick();
    end
    check($sformatf("u%0d idle busy", u), 32'(busy[u]), 32'd0);
    check($sformatf("u%0d idle d_ready", u), 32'(d_ready[u]), 32'd1);
    check($sformatf("u%0d idle sframe", u), 32'(sframe[u]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    resetn  = 1'b0;
    d_valid = 3'b000;
    for (int u = 0; u < 3; u++) d[u] = 8'h00;
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("u%0d rst d_ready", u), 32'(d_ready[u]), 32'd1);
      check($sformatf("u%0d rst busy", u), 32'(busy[u]), 32'd0);
      check($sformatf("u%0d rst sframe", u), 32'(sframe[u]), 32'd0);
      check($sformatf("u%0d rst sdo", u), 32'(sdo[u]), 32'd0);
    end
    // d_valid under reset must not start a frame.
    d[0] = 8'hFF;
    d_valid[0] = 1'b1;
    tick();
    check("rst no accept busy", 32'(busy[0]), 32'd0);
    check("rst no accept sframe", 32'(sframe[0]), 32'd0);
    d_valid[0] = 1'b0;
    resetn = 1'b1;
    tick();

    // 0xA5, GAP = 1.
    d[0] = 8'hA5;
    d_valid[0] = 1'b1;
    tick();
    d_valid[0] = 1'b0;
    d[0] = 8'h00;
    run_frame(0, 8'hA5, -1, 8'h00);

    // 0x07: odd number of ones, parity bit 1 when compiled in.
    d[0] = 8'h07;
    d_valid[0] = 1'b1;
    tick();
    d_valid[0] = 1'b0;
    run_frame(0, 8'h07, -1, 8'h00);

    // Back-to-back 0x3C then 0xC3 with d_valid held, GAP = 2.
    d[1] = 8'h3C;
    d_valid[1] = 1'b1;
    tick();
    c0 = cyc;
    check("b2b first accept busy", 32'(busy[1]), 32'd1);
    d[1] = 8'hC3;
    run_frame(1, 8'h3C, -1, 8'h00);
    tick();
    check("b2b second accept busy", 32'(busy[1]), 32'd1);
    check("b2b accept spacing", 32'(cyc - c0), 32'(8 + P + 2 + 1));
    d_valid[1] = 1'b0;
    run_frame(1, 8'hC3, -1, 8'h00);

    // 0x00 accepted, d changes to 0xFF two cycles later with d_valid held.
    d[0] = 8'h00;
    d_valid[0] = 1'b1;
    tick();
    c0 = cyc;
    run_frame(0, 8'h00, 2, 8'hFF);
    tick();
    check("late FF accept busy", 32'(busy[0]), 32'd1);
    check("late FF spacing", 32'(cyc - c0), 32'(8 + P + 1 + 1));
    d_valid[0] = 1'b0;
    run_frame(0, 8'hFF, -1, 8'h00);

    // Async reset during bit 3 of 0x5A (bit 3 of the frame is d[4] = 1).
    d[0] = 8'h5A;
    d_valid[0] = 1'b1;
    tick();
    d_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    check("pre-reset bit3 sdo", 32'(sdo[0]), 32'd1);
    check("pre-reset bit3 sframe", 32'(sframe[0]), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst sdo", 32'(sdo[0]), 32'd0);
    check("async rst sframe", 32'(sframe[0]), 32'd0);
    check("async rst busy", 32'(busy[0]), 32'd0);
    check("async rst d_ready", 32'(d_ready[0]), 32'd1);
    tick();
    resetn = 1'b1;
    tick();
    check("post-rst idle sframe", 32'(sframe[0]), 32'd0);
    d[0] = 8'h96;
    d_valid[0] = 1'b1;
    tick();
    d_valid[0] = 1'b0;
    run_frame(0, 8'h96, -1, 8'h00);

    // GAP = 0, d_valid held on 0x81: one IDLE cycle between frames.
    d[2] = 8'h81;
    d_valid[2] = 1'b1;
    tick();
    c0 = cyc;
    run_frame(2, 8'h81, -1, 8'h00);
    tick();
    check("gap0 second accept busy", 32'(busy[2]), 32'd1);
    check("gap0 accept spacing", 32'(cyc - c0), 32'(8 + P + 0 + 1));
    d_valid[2] = 1'b0;
    run_frame(2, 8'h81, -1, 8'h00);
    tick();
    check("gap0 stays idle", 32'(busy[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
